// File: rtl/paint_mem_scheduler_pkg.sv
// Shared types and helpers for the paint frame-buffer scheduler.
// The frame buffer is row-major with a 640-pixel stride and 4-bit pixels.
package paint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAMP = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int FB_WORDS = 307200;

  // y*640 + x as two shifts and an add; 479*640+639 still fits in 19 bits
  function automatic logic [18:0] xy_to_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] w_y;
    w_y = {9'd0, y};
    return (w_y << 9) + (w_y << 7) + {9'd0, x};
  endfunction

endpackage

// File: rtl/paint_mem_scheduler_brush_window_iter.sv
// Walks the (2R+1)^2 window around the brush centre, dx fastest, and flags
// candidates that fall inside the disk and on screen.
module brush_window_iter
  import paint_pkg::*;
#(
  parameter int BRUSH_R = 2,
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [9:0]  i_cx,
  input  logic [9:0]  i_cy,
  output logic        o_writable,
  output logic [18:0] o_addr,
  output logic        o_last
);

  localparam logic signed [11:0] R    = 12'(BRUSH_R);
  localparam logic signed [11:0] XM   = 12'(X_MAX);
  localparam logic signed [11:0] YM   = 12'(Y_MAX);
  localparam logic signed [23:0] R_SQ = 24'(BRUSH_R * BRUSH_R);

  logic signed [11:0] r_dx, r_dy;
  logic signed [11:0] w_px, w_py;
  logic signed [23:0] w_dx_w, w_dy_w, w_d2;
  logic               w_in_disk, w_on_screen;

  // Signed 12-bit math keeps off-screen candidates negative rather than wrapping
  assign w_px   = $signed({2'b00, i_cx}) + r_dx;
  assign w_py   = $signed({2'b00, i_cy}) + r_dy;
  assign w_dx_w = 24'(r_dx);
  assign w_dy_w = 24'(r_dy);
  assign w_d2   = w_dx_w * w_dx_w + w_dy_w * w_dy_w;

  assign w_in_disk   = (w_d2 <= R_SQ);
  assign w_on_screen = !w_px[11] && !w_py[11] && (w_px <= XM) && (w_py <= YM);
  assign o_writable  = w_in_disk && w_on_screen;
  assign o_addr      = xy_to_addr(w_px[9:0], w_py[9:0]);
  assign o_last      = (r_dx == R) && (r_dy == R);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dx <= '0;
      r_dy <= '0;
    end else if (i_load) begin
      r_dx <= -R;
      r_dy <= -R;
    end else if (i_advance) begin
      if (r_dx == R) begin
        r_dx <= -R;
        r_dy <= r_dy + 12'sd1;
      end else begin
        r_dx <= r_dx + 12'sd1;
      end
    end
  end

endmodule

// File: rtl/paint_mem_scheduler.sv
// Arbitrates the single-port paint frame buffer between scanout reads,
// brush stamps and a clear sweep; scanout always owns the port when it asks.
module paint_mem_scheduler
  import paint_pkg::*;
#(
  parameter int BRUSH_R     = 2,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int ADDR_W      = 19,
  parameter int CLEAR_WORDS = FB_WORDS
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              laser_valid,
  input  logic [10:0]       xLaser,
  input  logic [10:0]       yLaser,
  input  logic [3:0]        paint_color,
  input  logic              clear_req,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wdata,
  output logic              busy,
  output logic              stamp_done,
  output logic              clear_done
);

  localparam logic [18:0] CLR_LAST = 19'(CLEAR_WORDS - 1);

  state_t      r_state, w_next;
  logic [9:0]  r_cx, r_cy;
  logic [3:0]  r_color;
  logic        r_clear_pend;
  logic [18:0] r_clr_addr;
  logic        r_stamp_done, r_clear_done;

  logic        w_load, w_adv, w_wr_pend, w_stamp_fin, w_clear_fin, w_we;
  logic        w_writable, w_last;
  logic [18:0] w_st_addr, w_tgt;
  logic        w_unused;

  // Camera coordinates are double the screen resolution; the LSB is dropped
  assign w_unused = ^{xLaser[0], yLaser[0]};

  brush_window_iter #(
    .BRUSH_R (BRUSH_R),
    .X_MAX   (X_MAX),
    .Y_MAX   (Y_MAX)
  ) u_iter (
    .clk        (Clk),
    .rst        (Reset),
    .i_load     (w_load),
    .i_advance  (w_adv),
    .i_cx       (r_cx),
    .i_cy       (r_cy),
    .o_writable (w_writable),
    .o_addr     (w_st_addr),
    .o_last     (w_last)
  );

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_wr_pend   = 1'b0;
    w_tgt       = r_clr_addr;
    w_stamp_fin = 1'b0;
    w_clear_fin = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_req) begin
          w_next = CLEAR;
        end else if (laser_valid) begin
          w_next = STAMP;
          w_load = 1'b1;
        end
      end
      STAMP: begin
        w_wr_pend = w_writable;
        w_tgt     = w_st_addr;
        // Only writable candidates wait for the port; the rest skip through
        w_adv     = !w_writable || !vga_req;
        if (w_adv && w_last) begin
          w_stamp_fin = 1'b1;
          w_next      = (r_clear_pend || clear_req) ? CLEAR : IDLE;
        end
      end
      CLEAR: begin
        w_wr_pend = 1'b1;
        if (!vga_req && (r_clr_addr == CLR_LAST)) begin
          w_clear_fin = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_cx         <= '0;
      r_cy         <= '0;
      r_color      <= '0;
      r_clear_pend <= 1'b0;
      r_clr_addr   <= '0;
      r_stamp_done <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_stamp_done <= w_stamp_fin;
      r_clear_done <= w_clear_fin;
      if (w_load) begin
        r_cx    <= xLaser[10:1];
        r_cy    <= yLaser[10:1];
        r_color <= paint_color;
      end
      if (r_state == STAMP)
        r_clear_pend <= (r_clear_pend || clear_req) && !w_stamp_fin;
      else
        r_clear_pend <= 1'b0;
      if (r_state != CLEAR)
        r_clr_addr <= '0;
      else if (!vga_req)
        r_clr_addr <= r_clr_addr + 19'd1;
    end
  end

  // Reset gates the write so an aborted operation never lands a stray pixel
  assign w_we       = w_wr_pend && !vga_req && !Reset;
  assign mem_we     = w_we;
  assign mem_addr   = w_we ? ADDR_W'(w_tgt) : vga_addr;
  assign mem_wdata  = (r_state == STAMP) ? r_color : 4'd0;
  assign busy       = (r_state != IDLE);
  assign stamp_done = r_stamp_done;
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_paint_mem_scheduler.sv
// Directed checks of stamp geometry, scanout priority, clear sequencing and reset abort.
module tb_paint_mem_scheduler;

  localparam int CLR_W = 1024;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        laser_valid = 1'b0;
  logic [10:0] xLaser = '0;
  logic [10:0] yLaser = '0;
  logic [3:0]  paint_color = '0;
  logic        clear_req = 1'b0;
  logic        vga_req = 1'b0;
  logic [18:0] vga_addr = 19'h5A5A5;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic        busy, stamp_done, clear_done;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_addr[$];
  int wr_data[$];
  int n_sd = 0, sd_cyc = 0, n_cd = 0, cd_cyc = 0;
  int n_clash = 0, n_bad_vaddr = 0;
  int n0, s0, c0;

  paint_mem_scheduler #(
    .BRUSH_R(2), .X_MAX(639), .Y_MAX(479), .ADDR_W(19), .CLEAR_WORDS(CLR_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .laser_valid(laser_valid), .xLaser(xLaser),
    .yLaser(yLaser), .paint_color(paint_color), .clear_req(clear_req),
    .vga_req(vga_req), .vga_addr(vga_addr), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy),
    .stamp_done(stamp_done), .clear_done(clear_done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_wdata));
      if (vga_req) n_clash++;
    end
    if (vga_req && (mem_addr !== vga_addr)) n_bad_vaddr++;
    if (stamp_done === 1'b1) begin n_sd++; sd_cyc = cyc; end
    if (clear_done === 1'b1) begin n_cd++; cd_cyc = cyc; end
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  function automatic int cnt_data(input int v);
    int c = 0;
    foreach (wr_data[i]) if (wr_data[i] == v) c++;
    return c;
  endfunction

  function automatic int sum_addr_data(input int v);
    int s = 0;
    foreach (wr_data[i]) if (wr_data[i] == v) s += wr_addr[i];
    return s;
  endfunction

  function automatic int has_addr(input int a);
    foreach (wr_addr[i]) if (wr_addr[i] == a) return 1;
    return 0;
  endfunction

  function automatic int max_addr();
    int m = -1;
    foreach (wr_addr[i]) if (wr_addr[i] > m) m = wr_addr[i];
    return m;
  endfunction

  task automatic start_laser(input int x, input int y, input logic [3:0] col);
    xLaser = 11'(x); yLaser = 11'(y); paint_color = col;
    laser_valid = 1'b1; n0 = cyc; s0 = n_sd; c0 = n_cd;
  endtask

  task automatic wait_stamp(input int budget);
    for (int k = 0; k < budget && n_sd == s0; k++) begin
      step(1);
      laser_valid = 1'b0;
    end
    laser_valid = 1'b0;
    chk_eq("stamp_done_seen", 32'(n_sd - s0), 1);
  endtask

  initial begin
    // Reset state
    step(3);
    @(negedge Clk);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_we", 32'(mem_we), 0);
    chk_eq("rst_wdata", 32'(mem_wdata), 0);
    chk_eq("rst_sdone", 32'(stamp_done), 0);
    chk_eq("rst_cdone", 32'(clear_done), 0);
    chk_eq("rst_addr", 32'(mem_addr), 32'h5A5A5);
    step(1);
    Reset = 1'b0;
    step(1);

    // Centre stamp: centre (320,240), 13 disk pixels summing to 13*153920
    clear_log();
    start_laser(640, 480, 4'hB);
    step(1);
    laser_valid = 1'b0;
    @(negedge Clk);
    chk_eq("t1_busy_n1", 32'(busy), 1);
    wait_stamp(60);
    chk_eq("t1_done_cyc", 32'(sd_cyc - n0), 26);
    step(1);
    chk_eq("t1_busy_end", 32'(busy), 0);
    chk_eq("t1_nwr", 32'(wr_addr.size()), 13);
    chk_eq("t1_ncol", 32'(cnt_data(11)), 13);
    chk_eq("t1_sum", 32'(sum_addr_data(11)), 2000960);
    chk_eq("t1_left", 32'(has_addr(153918)), 1);
    chk_eq("t1_top", 32'(has_addr(152640)), 1);

    // Corner stamp at (0,0)
    clear_log();
    start_laser(0, 0, 4'h5);
    wait_stamp(60);
    chk_eq("t2_done_cyc", 32'(sd_cyc - n0), 26);
    step(1);
    chk_eq("t2_nwr", 32'(wr_addr.size()), 6);
    chk_eq("t2_sum", 32'(sum_addr_data(5)), 2564);
    chk_eq("t2_max", 32'(max_addr()), 1280);
    chk_eq("t2_a0", 32'(has_addr(0)), 1);
    chk_eq("t2_a641", 32'(has_addr(641)), 1);

    // Alternate-cycle scanout during a centre stamp: 9 stalls on writable candidates
    clear_log();
    n_clash = 0; n_bad_vaddr = 0;
    start_laser(640, 480, 4'h9);
    for (int k = 0; k < 80 && n_sd == s0; k++) begin
      step(1);
      laser_valid = 1'b0;
      vga_req = ((cyc - n0) % 2) == 1;
    end
    vga_req = 1'b0;
    chk_eq("t3_done_seen", 32'(n_sd - s0), 1);
    chk_eq("t3_done_cyc", 32'(sd_cyc - n0), 35);
    step(1);
    chk_eq("t3_nwr", 32'(wr_addr.size()), 13);
    chk_eq("t3_sum", 32'(sum_addr_data(9)), 2000960);
    chk_eq("t3_clash", 32'(n_clash), 0);
    chk_eq("t3_vaddr", 32'(n_bad_vaddr), 0);

    // clear_req mid-stamp; laser during the clear is dropped
    clear_log();
    start_laser(640, 480, 4'h7);
    for (int k = 0; k < 1200 && n_cd == c0; k++) begin
      step(1);
      clear_req   = (cyc == n0 + 5);
      laser_valid = (cyc == n0 + 100);
    end
    clear_req = 1'b0; laser_valid = 1'b0;
    chk_eq("t4_cdone_seen", 32'(n_cd - c0), 1);
    chk_eq("t4_sdone_cyc", 32'(sd_cyc - n0), 26);
    chk_eq("t4_cdone_cyc", 32'(cd_cyc - n0), 1050);
    step(3);
    chk_eq("t4_cdone_once", 32'(n_cd - c0), 1);
    chk_eq("t4_sdone_once", 32'(n_sd - s0), 1);
    chk_eq("t4_paint_wr", 32'(cnt_data(7)), 13);
    chk_eq("t4_zero_wr", 32'(cnt_data(0)), CLR_W);
    chk_eq("t4_zero_sum", 32'(sum_addr_data(0)), 523776);
    chk_eq("t4_total_wr", 32'(wr_addr.size()), 13 + CLR_W);
    chk_eq("t4_busy_end", 32'(busy), 0);

    // Simultaneous clear_req and laser_valid in IDLE
    clear_log();
    start_laser(640, 480, 4'hC);
    clear_req = 1'b1;
    for (int k = 0; k < 1200 && n_cd == c0; k++) begin
      step(1);
      clear_req = 1'b0; laser_valid = 1'b0;
    end
    chk_eq("t5_cdone_cyc", 32'(cd_cyc - n0), 1025);
    step(2);
    chk_eq("t5_no_stamp", 32'(n_sd - s0), 0);
    chk_eq("t5_nonzero_wr", 32'(wr_addr.size() - cnt_data(0)), 0);
    chk_eq("t5_zero_wr", 32'(cnt_data(0)), CLR_W);

    // Reset while candidate 7 is presented
    clear_log();
    start_laser(640, 480, 4'h3);
    step(1);
    laser_valid = 1'b0;
    step(6);
    Reset = 1'b1;
    @(negedge Clk);
    chk_eq("t6_we_in_rst", 32'(mem_we), 0);
    step(1);
    Reset = 1'b0;
    @(negedge Clk);
    chk_eq("t6_busy_after", 32'(busy), 0);
    chk_eq("t6_we_after", 32'(mem_we), 0);
    chk_eq("t6_nwr", 32'(wr_addr.size()), 1);
    chk_eq("t6_addr", 32'(has_addr(152640)), 1);
    step(1);
    clear_log();
    start_laser(640, 480, 4'hE);
    wait_stamp(60);
    chk_eq("t6_restamp_cyc", 32'(sd_cyc - n0), 26);
    step(1);
    chk_eq("t6_restamp_nwr", 32'(cnt_data(14)), 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
